conv_frame_sequencer: RTL and testbench

- Controller that sequences the 5-stage, 3-channel 3x3 Sobel convolution datapath over one raster-scan RGB frame.
- Tracks input pixel row and column, and drives line-buffer write and window-shift enables.
- Flags which input pixels complete a valid 3x3 window, delays that flag by the pipeline latency, and produces the Save strobe.
- Counts output pixels and signals frame completion. Sits between the pixel source and top_CNN_Image_Processor's datapath.

---
 rtl/conv_seq_pkg.sv | 30 +++
 rtl/valid_delay_line.sv | 23 ++
 rtl/conv_frame_sequencer.sv | 126 ++++++++++++
 tb/tb_conv_frame_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and sizing helpers for the Sobel frame sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    function automatic int unsigned out_w(input int unsigned img_w, input int unsigned k);
        return img_w - k + 1;
    endfunction

    function automatic int unsigned out_h(input int unsigned img_h, input int unsigned k);
        return img_h - k + 1;
    endfunction

    function automatic int unsigned out_n(input int unsigned img_w, input int unsigned img_h,
                                          input int unsigned k);
        return out_w(img_w, k) * out_h(img_h, k);
    endfunction

    // Bits needed to index n distinct values, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register that aligns window-valid with the datapath result.
module valid_delay_line #(
    parameter int unsigned DEPTH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else begin
            taps <= DEPTH'({taps, d});
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Raster-scan controller for the 3-channel 3x3 convolution datapath: pixel indexing,
// line-buffer/window enables, window-valid tracking, Save strobe and frame completion.
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned IMG_W    = 128,
    parameter int unsigned IMG_H    = 128,
    parameter int unsigned K        = 3,
    parameter int unsigned PIPE_LAT = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       S,
    input  logic                       in_valid,
    output logic                       lb_wr_en,
    output logic                       shift_en,
    output logic                       win_valid,
    output logic [$clog2(IMG_W)-1:0]   col,
    output logic [$clog2(IMG_H)-1:0]   row,
    output logic                       Save,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned OUT_N = out_n(IMG_W, IMG_H, K);
    localparam int unsigned CNT_W = cnt_w(OUT_N + 1);

    seq_state_e        state;
    logic [CNT_W-1:0]  out_cnt;
    logic              accept;
    logic              last_px;
    logic              fill_end;
    logic              out_done;

    // Accept decode and enables; indices are the pre-increment position of this pixel.
    always_comb begin
        accept    = 1'b0;
        lb_wr_en  = 1'b0;
        shift_en  = 1'b0;
        win_valid = 1'b0;
        accept    = ((state == FILL) || (state == RUN)) && in_valid;
        lb_wr_en  = accept;
        shift_en  = accept;
        win_valid = accept && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
        last_px   = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
        fill_end  = (row == ROW_W'(K - 1)) && (col == COL_W'(K - 2));
        // Counter reaches OUT_N this cycle or already sits there.
        out_done  = (out_cnt == CNT_W'(OUT_N)) ||
                    (Save && (out_cnt == CNT_W'(OUT_N - 1)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            out_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (accept) begin
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    if (row != ROW_W'(IMG_H - 1)) begin
                        row <= row + ROW_W'(1);
                    end
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            if (Save && (out_cnt != CNT_W'(OUT_N))) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (S) begin
                        state <= FILL;
                        busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept && fill_end) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept && last_px) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_done) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    col     <= '0;
                    row     <= '0;
                    out_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (reset),
        .d     (win_valid),
        .q     (Save)
    );

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench: a default 128x128 instance and a small 5x4 instance, both checked
// every cycle against a frame-level reference model, plus literal checks pinning the model.
module tb_conv_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, s0, iv0, s1, iv1;
    logic o0_lb, o0_sh, o0_win, o0_save, o0_busy, o0_fd;
    logic [6:0] o0_col, o0_row;
    logic o1_lb, o1_sh, o1_win, o1_save, o1_busy, o1_fd;
    logic [2:0] o1_col;
    logic [1:0] o1_row;

    conv_frame_sequencer u_dut0 (
        .clk(clk), .reset(rst_n), .S(s0), .in_valid(iv0),
        .lb_wr_en(o0_lb), .shift_en(o0_sh), .win_valid(o0_win),
        .col(o0_col), .row(o0_row), .Save(o0_save), .busy(o0_busy), .frame_done(o0_fd)
    );

    conv_frame_sequencer #(.IMG_W(5), .IMG_H(4), .K(3), .PIPE_LAT(2)) u_dut1 (
        .clk(clk), .reset(rst_n), .S(s1), .in_valid(iv1),
        .lb_wr_en(o1_lb), .shift_en(o1_sh), .win_valid(o1_win),
        .col(o1_col), .row(o1_row), .Save(o1_save), .busy(o1_busy), .frame_done(o1_fd)
    );

    int n_cmp = 0;
    int n_err = 0;
    int tcyc  = 0;

    // Model: phase 0 idle, 1 taking pixels, 2 waiting for outputs, 3 done pulse.
    int mw[2] = '{128, 5};
    int mh[2] = '{128, 4};
    int mk[2] = '{3, 3};
    int ml[2] = '{5, 2};
    int m_phase[2] = '{0, 0};
    int m_idx[2]   = '{0, 0};
    int m_nsave[2] = '{0, 0};
    bit hist[2][64];

    // Observations for literal checks.
    int acc0 = 0, first_win_acc = -1, first_win_cyc = -1, first_save_cyc = -1;
    int saves0[4] = '{0, 0, 0, 0};
    int fd0 = 0, busy_after = -1;
    bit chk_busy_next = 1'b0;
    int idx1 = 0, nsave1 = 0, sixth_cyc = -1, fd1_cyc = -1, fd1 = 0;
    int win_idx1[$];
    int exp_win[6] = '{12, 13, 14, 17, 18, 19};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    task automatic model_step(input int i, input int rs, input int s, input int iv,
                              input int lb, input int sh, input int win, input int col,
                              input int row, input int save, input int busy, input int fd);
        string p;
        int w, h, k, l, n, r, c, e_acc, e_win, e_save;
        p = (i == 0) ? "big" : "small";
        w = mw[i]; h = mh[i]; k = mk[i]; l = ml[i];
        n = (w - k + 1) * (h - k + 1);
        if (rs == 0) begin
            check({p, "_rst_lb"}, lb, 0);
            check({p, "_rst_sh"}, sh, 0);
            check({p, "_rst_win"}, win, 0);
            check({p, "_rst_col"}, col, 0);
            check({p, "_rst_row"}, row, 0);
            check({p, "_rst_save"}, save, 0);
            check({p, "_rst_busy"}, busy, 0);
            check({p, "_rst_fd"}, fd, 0);
            m_phase[i] = 0; m_idx[i] = 0; m_nsave[i] = 0;
            for (int j = 0; j < 64; j++) hist[i][j] = 1'b0;
            return;
        end
        e_acc = (m_phase[i] == 1 && iv != 0) ? 1 : 0;
        r = m_idx[i] / w;
        if (r > h - 1) r = h - 1;
        c = m_idx[i] % w;
        e_win  = (e_acc == 1 && r >= k - 1 && c >= k - 1) ? 1 : 0;
        e_save = (tcyc >= l) ? int'(hist[i][(tcyc - l) % 64]) : 0;
        hist[i][tcyc % 64] = (e_win != 0);
        check({p, "_lb_wr_en"}, lb, e_acc);
        check({p, "_shift_en"}, sh, e_acc);
        check({p, "_win_valid"}, win, e_win);
        check({p, "_col"}, col, c);
        check({p, "_row"}, row, r);
        check({p, "_save"}, save, e_save);
        check({p, "_busy"}, busy, (m_phase[i] != 0) ? 1 : 0);
        check({p, "_frame_done"}, fd, (m_phase[i] == 3) ? 1 : 0);
        if (e_save == 1 && m_nsave[i] < n) m_nsave[i]++;
        case (m_phase[i])
            0: if (s != 0) m_phase[i] = 1;
            1: if (e_acc == 1) begin
                   m_idx[i]++;
                   if (m_idx[i] == w * h) m_phase[i] = 2;
               end
            2: if (m_nsave[i] == n) m_phase[i] = 3;
            default: begin m_phase[i] = 0; m_idx[i] = 0; m_nsave[i] = 0; end
        endcase
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        model_step(0, int'(rst_n), int'(s0), int'(iv0), int'(o0_lb), int'(o0_sh),
                   int'(o0_win), int'(o0_col), int'(o0_row), int'(o0_save),
                   int'(o0_busy), int'(o0_fd));
        model_step(1, int'(rst_n), int'(s1), int'(iv1), int'(o1_lb), int'(o1_sh),
                   int'(o1_win), int'(o1_col), int'(o1_row), int'(o1_save),
                   int'(o1_busy), int'(o1_fd));
        if (o0_lb) acc0++;
        if (o0_win && first_win_acc < 0) begin
            first_win_acc = acc0;
            first_win_cyc = tcyc;
        end
        if (o0_save && first_save_cyc < 0) first_save_cyc = tcyc;
        if (o0_save && fd0 < 4) saves0[fd0]++;
        if (chk_busy_next) begin
            busy_after    = int'(o0_busy);
            chk_busy_next = 1'b0;
        end
        if (o0_fd) begin
            if (fd0 == 0) chk_busy_next = 1'b1;
            fd0++;
        end
        if (fd1 == 0) begin
            if (o1_win) win_idx1.push_back(idx1);
            if (o1_lb) idx1++;
            if (o1_save) begin
                nsave1++;
                if (nsave1 == 6) sixth_cyc = tcyc;
            end
            if (o1_fd) fd1_cyc = tcyc;
        end
        if (o1_fd) fd1++;
        tcyc++;
    end

    task automatic drive_small();
        iv1 = ($urandom_range(0, 9) < 7);
        s1  = ($urandom_range(0, 3) == 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        drive_small();
    endtask

    // mode 0: in_valid high with a 3-cycle drop at row 10 col 60, S again at row 50.
    // mode 1: random in_valid and S, S held from drain onwards.
    task automatic run_frame(input int mode);
        int start, n, dropped;
        start = fd0; n = 0; dropped = 0;
        while (fd0 == start && n < 40000) begin
            next_cycle();
            if (mode == 0) begin
                s0  = (m_phase[0] == 0) || (m_idx[0] / 128 == 50);
                iv0 = 1'b1;
                if (m_phase[0] == 1 && m_idx[0] == 10 * 128 + 60 && dropped < 3) begin
                    iv0 = 1'b0;
                    dropped++;
                end
            end else begin
                s0  = (m_phase[0] != 1) ? 1'b1 : ($urandom_range(0, 7) == 0);
                iv0 = ($urandom_range(0, 9) < 8);
            end
            n++;
        end
        if (fd0 == start) check("frame_timeout", 0, 1);
    endtask

    initial begin
        int n, quiet;
        rst_n = 1'b0; s0 = 1'b0; iv0 = 1'b0; s1 = 1'b0; iv1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_frame(0);
        repeat (4) begin
            next_cycle();
            s0 = 1'b0; iv0 = 1'b1;
        end
        run_frame(1);

        // Third frame, interrupted by reset at row 40.
        n = 0;
        while (m_idx[0] < 40 * 128 && n < 20000) begin
            next_cycle();
            s0  = (m_phase[0] == 0);
            iv0 = ($urandom_range(0, 9) < 8);
            n++;
        end
        if (m_idx[0] < 40 * 128) check("reset_row_timeout", 0, 1);
        next_cycle();
        rst_n = 1'b0; s0 = 1'b0; iv0 = 1'b1;
        #1;
        check("async_rst_busy", int'(o0_busy), 0);
        check("async_rst_row", int'(o0_row), 0);
        check("async_rst_col", int'(o0_col), 0);
        next_cycle();
        rst_n = 1'b1;
        quiet = 0;
        repeat (20) begin
            next_cycle();
            s0 = 1'b0; iv0 = 1'b1;
            #1;
            quiet += int'(o0_save) + int'(o0_lb) + int'(o0_busy) + int'(o0_col) + int'(o0_row);
        end
        check("post_reset_quiet", quiet, 0);
        next_cycle();

        check("first_win_pixel", first_win_acc, 259);
        check("first_save_latency", first_save_cyc - first_win_cyc, 5);
        check("frame1_saves", saves0[0], 15876);
        check("frame2_saves", saves0[1], 15876);
        check("frames_done", fd0, 2);
        check("busy_after_done", busy_after, 0);
        check("small_win_count", win_idx1.size(), 6);
        for (int j = 0; j < 6 && j < win_idx1.size(); j++)
            check($sformatf("small_win_idx%0d", j), win_idx1[j], exp_win[j]);
        check("small_saves", nsave1, 6);
        check("small_drain_exit", fd1_cyc - sixth_cyc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
